// File: rtl/predictor_update_arbiter.sv
// Predictor update arbiter: shares one BTB/PHT port between fetch lookups and queued branch updates.
// Latency: grant and table controls are combinational from state; an accepted update waits >=1 cycle in the queue.
// Backpressure: upd_ready falls when the queue is full, during a flush cycle and for the whole clear sweep.
//
// Ports:
//   CLK, RST                  clock and synchronous active-high reset
//   lookup_req/pc, lookup_gnt fetch read request and its grant
//   upd_valid/pc/target/taken resolved-branch update offer; upd_ready accepts it
//   flush_req, busy           table invalidation request and clear-sweep indicator
//   tbl_*                     single table port (enable, write, index, write payload)
module predictor_update_arbiter #(
  parameter int  TABLE_DEPTH  = 256,
  parameter int  FIFO_DEPTH   = 4,
  parameter int  STARVE_LIMIT = 8,
  localparam int IDX_W        = $clog2(TABLE_DEPTH),
  localparam int TAG_W        = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             lookup_req,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_gnt,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  input  logic             upd_taken,
  output logic             upd_ready,
  input  logic             flush_req,
  output logic             busy,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_idx,
  output logic [TAG_W-1:0] tbl_wtag,
  output logic [31:0]      tbl_wtarget,
  output logic             tbl_wtaken,
  output logic             tbl_wvalid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             taken;
  } upd_entry_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  upd_entry_t         fifo_mem_q [FIFO_DEPTH];

  logic               push;
  logic               pop;
  upd_entry_t         push_entry;
  upd_entry_t         head;

  // Only the index bits of the lookup PC and the word-aligned update PC matter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], upd_pc[1:0]};

  assign push_entry = '{idx: upd_pc[IDX_W+1:2], tag: upd_pc[31:IDX_W+2],
                        target: upd_target, taken: upd_taken};
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    starve_d    = starve_q;
    push        = 1'b0;
    pop         = 1'b0;
    lookup_gnt  = 1'b0;
    upd_ready   = 1'b0;
    busy        = 1'b0;
    tbl_en      = 1'b0;
    tbl_we      = 1'b0;
    tbl_idx     = '0;
    tbl_wtag    = '0;
    tbl_wtarget = '0;
    tbl_wtaken  = 1'b0;
    tbl_wvalid  = 1'b0;

    case (state_q)
      S_CLEAR: begin
        busy    = 1'b1;
        tbl_en  = 1'b1;
        tbl_we  = 1'b1;
        tbl_idx = clr_cnt_q;
        if (flush_req) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == IDX_W'(TABLE_DEPTH - 1)) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      default: begin
        if (flush_req) begin
          // Queued updates target a table about to be wiped, so drop them.
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          starve_d  = '0;
        end else begin
          // Fullness is judged before this cycle's pop, so a full queue never pushes.
          upd_ready = (count_q < CNT_W'(FIFO_DEPTH));
          push      = upd_valid && upd_ready;
          pop       = (count_q != '0) &&
                      (!lookup_req || (count_q == CNT_W'(FIFO_DEPTH)) ||
                       (starve_q >= STV_W'(STARVE_LIMIT)));
          if (pop) begin
            tbl_en      = 1'b1;
            tbl_we      = 1'b1;
            tbl_idx     = head.idx;
            tbl_wtag    = head.tag;
            tbl_wtarget = head.target;
            tbl_wtaken  = head.taken;
            tbl_wvalid  = 1'b1;
          end else if (lookup_req) begin
            lookup_gnt = 1'b1;
            tbl_en     = 1'b1;
            tbl_idx    = lookup_pc[IDX_W+1:2];
          end

          if (pop || count_q == '0) begin
            starve_d = '0;
          end else if (starve_q < STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
          end

          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
    endcase

    if (state_q == S_RUN && flush_req) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_predictor_update_arbiter.sv
module tb_predictor_update_arbiter;

  localparam int TABLE_DEPTH  = 256;
  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int IDX_W        = $clog2(TABLE_DEPTH);
  localparam int TAG_W        = 30 - IDX_W;

  logic             CLK = 1'b0;
  logic             RST;
  logic             lookup_req;
  logic [31:0]      lookup_pc;
  logic             lookup_gnt;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic             upd_ready;
  logic             flush_req;
  logic             busy;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  logic [TAG_W-1:0] tbl_wtag;
  logic [31:0]      tbl_wtarget;
  logic             tbl_wtaken;
  logic             tbl_wvalid;

  int total = 0;
  int bad   = 0;

  predictor_update_arbiter #(
    .TABLE_DEPTH(TABLE_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .lookup_req(lookup_req), .lookup_pc(lookup_pc), .lookup_gnt(lookup_gnt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_ready(upd_ready),
    .flush_req(flush_req), .busy(busy),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_wtag(tbl_wtag),
    .tbl_wtarget(tbl_wtarget), .tbl_wtaken(tbl_wtaken), .tbl_wvalid(tbl_wvalid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a sweep position, a queue of pending updates and a denial counter.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_t;

  bit   m_valid   = 1'b0;
  bit   m_clear;
  int   m_pos;
  int   m_denied;
  upd_t m_q[$];

  always @(negedge CLK) begin : model
    logic        e_gnt, e_rdy, e_busy, e_en, e_we, e_wtaken, e_wvalid;
    logic [31:0] e_idx, e_wtag, e_wtarget;
    bit          wr;
    int          sz;
    upd_t        u;
    e_gnt = 0; e_rdy = 0; e_busy = 0; e_en = 0; e_we = 0; e_wtaken = 0; e_wvalid = 0;
    e_idx = 0; e_wtag = 0; e_wtarget = 0;
    wr = 0;
    sz = m_q.size();
    if (m_clear) begin
      e_busy = 1; e_en = 1; e_we = 1; e_idx = 32'(m_pos);
    end else if (!flush_req) begin
      e_rdy = (sz < FIFO_DEPTH);
      wr = (sz > 0) && (!lookup_req || sz == FIFO_DEPTH || m_denied >= STARVE_LIMIT);
      if (wr) begin
        e_en = 1; e_we = 1; e_wvalid = 1;
        e_idx     = (m_q[0].pc >> 2) % TABLE_DEPTH;
        e_wtag    = m_q[0].pc >> (IDX_W + 2);
        e_wtarget = m_q[0].target;
        e_wtaken  = m_q[0].taken;
      end else if (lookup_req) begin
        e_gnt = 1; e_en = 1;
        e_idx = (lookup_pc >> 2) % TABLE_DEPTH;
      end
    end
    if (m_valid) begin
      chk("busy",        32'(busy),        e_busy);
      chk("lookup_gnt",  32'(lookup_gnt),  e_gnt);
      chk("upd_ready",   32'(upd_ready),   e_rdy);
      chk("tbl_en",      32'(tbl_en),      e_en);
      chk("tbl_we",      32'(tbl_we),      e_we);
      chk("tbl_idx",     32'(tbl_idx),     e_idx);
      chk("tbl_wtag",    32'(tbl_wtag),    e_wtag);
      chk("tbl_wtarget", tbl_wtarget,      e_wtarget);
      chk("tbl_wtaken",  32'(tbl_wtaken),  e_wtaken);
      chk("tbl_wvalid",  32'(tbl_wvalid),  e_wvalid);
    end
    // Advance to the state after the coming rising edge.
    if (RST) begin
      m_valid = 1; m_clear = 1; m_pos = 0; m_denied = 0; m_q.delete();
    end else if (m_valid) begin
      if (m_clear) begin
        if (flush_req)                     m_pos = 0;
        else if (m_pos == TABLE_DEPTH - 1) begin m_clear = 0; m_pos = 0; end
        else                               m_pos++;
      end else if (flush_req) begin
        m_clear = 1; m_pos = 0; m_denied = 0; m_q.delete();
      end else begin
        if (wr) void'(m_q.pop_front());
        if (upd_valid && e_rdy) begin
          u.pc = upd_pc; u.target = upd_target; u.taken = upd_taken;
          m_q.push_back(u);
        end
        if (wr || sz == 0)               m_denied = 0;
        else if (m_denied < STARVE_LIMIT) m_denied++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin : stim
    int n;
    int g;
    RST = 1; lookup_req = 0; lookup_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_target = 0; upd_taken = 0; flush_req = 0;
    tick(); tick();
    RST = 0;
    #1;
    chk("rst_busy",  32'(busy),      32'd1);
    chk("rst_idx",   32'(tbl_idx),   32'd0);
    chk("rst_we",    32'(tbl_we),    32'd1);
    chk("rst_wvld",  32'(tbl_wvalid), 32'd0);
    chk("rst_rdy",   32'(upd_ready), 32'd0);
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk("sweep_len", 32'(n), 32'd256);
    chk("run_rdy",   32'(upd_ready), 32'd1);

    // Single update starved behind continuous lookups.
    lookup_req = 1; lookup_pc = 32'h0000_0040;
    upd_valid = 1; upd_pc = 32'h0000_1004; upd_target = 32'h0000_2000; upd_taken = 1;
    tick();
    upd_valid = 0;
    #1;
    g = 0;
    while (!tbl_we && g < 40) begin
      if (lookup_gnt) g++;
      tick(); #1;
    end
    chk("starve_grants", 32'(g),        32'd8);
    chk("starve_idx",    32'(tbl_idx),  32'd1);
    chk("starve_tag",    32'(tbl_wtag), 32'h4);
    chk("starve_tgt",    tbl_wtarget,   32'h0000_2000);
    chk("starve_gnt",    32'(lookup_gnt), 32'd0);

    // No lookups: A then B written on consecutive cycles.
    lookup_req = 0;
    upd_valid = 1; upd_pc = 32'h0000_0108; upd_target = 32'hAAAA_0000; upd_taken = 0;
    tick();
    upd_pc = 32'h0000_020C; upd_target = 32'hBBBB_0000; upd_taken = 1;
    #1;
    chk("a_tgt", tbl_wtarget,   32'hAAAA_0000);
    chk("a_idx", 32'(tbl_idx),  32'h42);
    tick();
    upd_valid = 0;
    #1;
    chk("b_tgt", tbl_wtarget,   32'hBBBB_0000);
    chk("b_idx", 32'(tbl_idx),  32'h83);
    tick(); #1;
    chk("drained_en", 32'(tbl_en), 32'd0);

    // Fill the queue under lookups: full queue forces a write.
    lookup_req = 1; upd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      upd_pc = $urandom; upd_target = $urandom; upd_taken = 1'($urandom);
      tick();
    end
    upd_valid = 0;
    #1;
    chk("full_rdy", 32'(upd_ready),  32'd0);
    chk("full_we",  32'(tbl_we),     32'd1);
    chk("full_gnt", 32'(lookup_gnt), 32'd0);
    tick();

    // Three remain queued; flush drops them and restarts the sweep.
    flush_req = 1;
    #1;
    chk("flush_en",  32'(tbl_en),    32'd0);
    chk("flush_rdy", 32'(upd_ready), 32'd0);
    tick();
    flush_req = 0; lookup_req = 0;
    #1;
    chk("flush_busy", 32'(busy),    32'd1);
    chk("flush_idx",  32'(tbl_idx), 32'd0);
    repeat (100) tick();
    #1;
    chk("mid_idx", 32'(tbl_idx), 32'd100);
    RST = 1;
    tick();
    RST = 0;
    #1;
    chk("rerst_idx",  32'(tbl_idx), 32'd0);
    chk("rerst_busy", 32'(busy),    32'd1);

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 6000; i++) begin
      tick();
      RST        = ($urandom % 700) == 0;
      flush_req  = ($urandom % 90) == 0;
      lookup_req = ($urandom % 4) != 0;
      lookup_pc  = $urandom;
      upd_valid  = ($urandom % 2) == 0;
      upd_pc     = $urandom;
      upd_target = $urandom;
      upd_taken  = 1'($urandom);
    end
    tick();
    RST = 0; flush_req = 0; lookup_req = 0; upd_valid = 0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/predictor_update_arbiter.md
PREDICTOR_UPDATE_ARBITER -- requirements
Module: predictor_update_arbiter

Interface
REQ-001 Parameter TABLE_DEPTH, default 256, number of BTB/PHT entries (power of 2, >=4).
REQ-002 Parameter FIFO_DEPTH, default 4, update queue entries (power of 2, >=2).
REQ-003 Parameter STARVE_LIMIT, default 8, cycles a queued update may be denied before forced priority.
REQ-004 Derived IDX_W = log2(TABLE_DEPTH); TAG_W = 30 - IDX_W.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 lookup_req  in  1  fetch requests table read this cycle.
REQ-008 lookup_pc  in  32  fetch PC.
REQ-009 lookup_gnt  out  1  table read issued this cycle.
REQ-010 upd_valid  in  1  resolved-branch update offered.
REQ-011 upd_pc  in  32  PC of resolved branch.
REQ-012 upd_target  in  32  resolved target address.
REQ-013 upd_taken  in  1  resolved direction.
REQ-014 upd_ready  out  1  update accepted when upd_valid && upd_ready.
REQ-015 flush_req  in  1  request full table invalidation.
REQ-016 busy  out  1  table clear sweep in progress.
REQ-017 tbl_en  out  1  table port enable.
REQ-018 tbl_we  out  1  table write (0 = read).
REQ-019 tbl_idx  out  IDX_W  table index.
REQ-020 tbl_wtag  out  TAG_W  write tag.
REQ-021 tbl_wtarget  out  32  write target.
REQ-022 tbl_wtaken  out  1  write direction bit.
REQ-023 tbl_wvalid  out  1  write valid bit.

Function
REQ-024 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2], for lookup and update alike.
REQ-025 Two states: CLEAR, RUN; RST -> CLEAR, clr_cnt = 0.
REQ-026 CLEAR: each cycle tbl_en=1, tbl_we=1, tbl_idx=clr_cnt, tbl_wvalid=0, tbl_wtag=0, tbl_wtarget=0, tbl_wtaken=0; clr_cnt increments.
REQ-027 CLEAR -> RUN after writing index TABLE_DEPTH-1 (exactly TABLE_DEPTH cycles); clr_cnt wraps to 0.
REQ-028 CLEAR: busy=1, lookup_gnt=0, upd_ready=0; flush_req during CLEAR restarts clr_cnt at 0.
REQ-029 RUN: busy=0; flush_req -> CLEAR next cycle, clr_cnt=0, FIFO emptied, starve_cnt=0; no push/pop and no grant that cycle.
REQ-030 upd_ready = RUN && !flush_req && count < FIFO_DEPTH, combinational; no push when full even if pop same cycle.
REQ-031 Accepted update pushed as {idx, tag, target, taken}; FIFO order strict; push+pop same cycle leaves count unchanged.
REQ-032 RUN single port per cycle: write wins if FIFO non-empty and (!lookup_req || count == FIFO_DEPTH || starve_cnt >= STARVE_LIMIT); else lookup wins if lookup_req.
REQ-033 Lookup grant: lookup_gnt=1, tbl_en=1, tbl_we=0, tbl_idx=lookup index; write fields 0.
REQ-034 Write grant: pop FIFO head, tbl_en=1, tbl_we=1, tbl_wvalid=1, fields from head; lookup_gnt=0.
REQ-035 Idle (no lookup, FIFO empty): tbl_en=0, tbl_we=0, all write fields 0.
REQ-036 starve_cnt: +1 per cycle FIFO non-empty and write denied, saturates at STARVE_LIMIT; 0 on write grant or FIFO empty.
REQ-037 No write-to-read forwarding; lookup of index with pending queued update returns stale table data.
REQ-038 Table read data path outside this block; grant timing only (1-cycle synchronous table read).

Reset
REQ-039 RST high at edge: state=CLEAR, clr_cnt=0, FIFO count=0, starve_cnt=0; overrides flush_req and all inputs.
REQ-040 Outputs in the cycle after reset: busy=1, lookup_gnt=0, upd_ready=0, tbl_en=1, tbl_we=1, tbl_idx=0, tbl_wvalid=0.
REQ-041 RST mid-sweep or mid-queue discards all state and restarts the sweep at index 0.

Verification
REQ-042 Reset, TABLE_DEPTH=256 -> 256 clear writes idx 0..255, busy drops on cycle 257, upd_ready=1.
REQ-043 RUN, lookup_req held 1, one update pushed pc=0x0000_1004 -> lookup granted 8 cycles, write idx=1 tag=0x4 on 9th cycle.
REQ-044 lookup_req held 1, push 4 updates back-to-back -> upd_ready=0 at count 4; next cycle write granted, lookup_gnt=0.
REQ-045 lookup_req=0, push updates A,B -> written A then B on consecutive cycles, FIFO empty after.
REQ-046 RUN with 3 queued updates, flush_req=1 -> no writes of queued data, 256-cycle clear sweep, count=0.
REQ-047 RST asserted at clr_cnt=100 -> next cycle tbl_idx=0, sweep restarts.
